// File: rtl/counter.sv
// Start/stop cycle counter: value runs 0..counter_overflow-1 and overflow pulses for one cycle on wrap.
// One-shot or autoreload; reset pauses and clears the count but leaves the running flag untouched.
module counter #(
   parameter int counter_overflow      = 16,
   parameter int counter_width         = $clog2(counter_overflow),
   parameter bit autostart             = 1'b0,
   parameter bit autoreload            = 1'b0,
   parameter bit start_resets_counting = 1'b0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   output logic [counter_width-1:0] value,
   output logic                     running,
   output logic                     overflow
);

   localparam logic [counter_width-1:0] last_count = counter_width'(counter_overflow - 1);

   logic                     run_q      = autostart;
   logic [counter_width-1:0] value_q    = '0;
   logic                     overflow_q = 1'b0;

   logic restart;
   logic at_last;
   logic wrap;

   // stop outranks start, so a simultaneous stop suppresses the restart and lets a wrap through
   always_comb begin
      restart = start & start_resets_counting & ~stop;
      at_last = (value_q == last_count);
      wrap    = run_q & at_last & ~restart;
   end

   // The running flag deliberately has no reset: reset only pauses and clears the count.
   always_ff @(posedge clock) begin
      if (stop) begin
         run_q <= 1'b0;
      end else if (start && !run_q) begin
         run_q <= 1'b1;
      end else if (wrap && !autoreload) begin
         run_q <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= wrap;
         if (restart) begin
            value_q <= '0;
         end else if (run_q) begin
            value_q <= at_last ? '0 : value_q + counter_width'(1);
         end
      end
   end

   assign value    = value_q;
   assign running  = run_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_counter.sv
// Four counter configurations driven by one shared directed-then-random stimulus stream.
`timescale 1ns/100ps
module tb_counter;

   localparam int N = 12;
   localparam int W = $clog2(N);
   localparam bit [3:0] AR  = 4'b1010;
   localparam bit [3:0] SRS = 4'b0110;
   localparam bit [3:0] AS  = 4'b1100;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic stop  = 1'b0;
   logic [W-1:0] val [4];
   logic         run [4];
   logic         ovf [4];

   int  m_val [4];
   bit  m_run [4];
   bit  m_ovf [4];
   int  checks = 0;
   int  errors = 0;

   always #1 clock = ~clock;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      counter #(
         .counter_overflow     (N),
         .autostart            (AS[g]),
         .autoreload           (AR[g]),
         .start_resets_counting(SRS[g])
      ) dut (
         .clock   (clock),
         .reset   (reset),
         .start   (start),
         .stop    (stop),
         .value   (val[g]),
         .running (run[g]),
         .overflow(ovf[g])
      );
   end

   task automatic chk(input string tag, input int i, input logic [W-1:0] got, input int exp);
      checks++;
      assert (got === W'(exp)) else begin
         errors++;
         $error("FAIL %s[%0d] at %0t: got %0d expected %0d", tag, i, $time, got, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         chk("value", i, val[i], m_val[i]);
         chk("running", i, W'(run[i]), int'(m_run[i]));
         chk("overflow", i, W'(ovf[i]), int'(m_ovf[i]));
      end
   endtask

   // Reference: one clock edge of the behaviour, per configuration.
   task automatic model_edge(input bit r, input bit s, input bit p);
      for (int i = 0; i < 4; i++) begin
         if (r) begin
            m_val[i] = 0;
            m_ovf[i] = 0;
            if (p) m_run[i] = 0;
            else if (s) m_run[i] = 1;
         end else begin
            m_ovf[i] = 0;
            if (p) begin
               if (m_run[i]) begin
                  m_ovf[i] = (m_val[i] == N - 1);
                  m_val[i] = (m_val[i] + 1) % N;
               end
               m_run[i] = 0;
            end else if (s && !m_run[i]) begin
               m_run[i] = 1;
               if (SRS[i]) m_val[i] = 0;
            end else if (s && SRS[i]) begin
               m_val[i] = 0;
            end else if (m_run[i]) begin
               if (m_val[i] == N - 1) begin
                  m_val[i] = 0;
                  m_ovf[i] = 1;
                  m_run[i] = AR[i];
               end else begin
                  m_val[i] = m_val[i] + 1;
               end
            end
         end
      end
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic drive(input bit r, input bit s, input bit p, input int n);
      for (int k = 0; k < n; k++) begin
         reset = r;
         start = s;
         stop  = p;
         if (r) begin
            for (int i = 0; i < 4; i++) begin
               m_val[i] = 0;
               m_ovf[i] = 0;
            end
         end
         @(posedge clock);
         model_edge(r, s, p);
         @(negedge clock);
         check_all();
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_val[i] = 0;
         m_ovf[i] = 0;
         m_run[i] = AS[i];
      end
      #0.5;
      check_all();

      drive(0, 0, 0, 2);
      drive(1, 0, 0, 3);
      drive(0, 0, 0, 2);
      drive(0, 0, 1, 1);
      drive(0, 0, 0, 2);

      drive(0, 1, 0, 1);
      drive(0, 0, 0, 14);

      drive(0, 1, 0, 6);
      drive(0, 1, 1, 3);
      drive(0, 0, 0, 3);

      drive(0, 1, 0, 1);
      drive(0, 0, 0, 4);
      drive(1, 1, 0, 3);
      drive(0, 0, 0, 3);

      drive(0, 1, 0, 2);
      drive(0, 0, 0, 4);
      drive(0, 1, 0, 3);
      drive(0, 0, 0, 5);

      drive(0, 0, 1, 1);
      drive(0, 1, 0, 1);
      drive(0, 0, 0, 30);
      drive(0, 0, 1, 2);
      drive(0, 0, 0, 2);

      drive(1, 0, 1, 2);
      drive(1, 1, 0, 2);
      drive(0, 0, 0, 11);
      drive(0, 0, 1, 1);
      drive(0, 0, 0, 2);

      for (int k = 0; k < 400; k++) begin
         drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 9) == 0), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
